// File: rtl/sic_alu_lock_arbiter.sv
// Shared-ALU lock manager: grants the single shared ALU to the oldest requesting
// SIC by issue_id, holds it until release/abort, and steers that SIC's request.
package sic_alu_lock_pkg;
   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } alu_req_t;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        carry;
   } alu_ans_t;
endpackage

// One SIC's arbitration cell: wins when it beats every other active requester.
module sic_alu_lock_lane #(
   parameter int NUM_SICS = 4,
   parameter int ID_WIDTH = 8,
   parameter int IDX      = 0
) (
   input  logic [NUM_SICS-1:0]               req,
   input  logic [NUM_SICS-1:0][ID_WIDTH-1:0] ids,
   output logic                              win
);
   logic [ID_WIDTH-1:0] diff;

   // Wrapping age: MSB of (mine - theirs) set means mine is older; ties go to lower index.
   always_comb begin
      win  = req[IDX];
      diff = '0;
      for (int j = 0; j < NUM_SICS; j++) begin
         if (j != IDX && req[j]) begin
            diff = ids[IDX] - ids[j];
            if (!(diff[ID_WIDTH-1] || (diff == '0 && IDX < j)))
               win = 1'b0;
         end
      end
   end
endmodule

module sic_alu_lock_arbiter
   import sic_alu_lock_pkg::*;
#(
   parameter  int NUM_SICS = 4,
   parameter  int ID_WIDTH = 8,
   localparam int OW       = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_SICS-1:0]               rpl_req,
   input  logic [NUM_SICS-1:0][ID_WIDTH-1:0] rpl_issue_id,
   input  logic [NUM_SICS-1:0]               rpl_release,
   input  alu_req_t [NUM_SICS-1:0]           sic_alu_req,
   output logic [NUM_SICS-1:0]               alu_grant,
   output alu_req_t                          alu_req_out,
   input  alu_ans_t                          alu_ans_in,
   output alu_ans_t                          alu_ans,
   output logic                              lock_busy,
   output logic [OW-1:0]                     lock_owner
);
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t              state;
   logic [NUM_SICS-1:0] win;
   logic [NUM_SICS-1:0] win_onehot;
   logic [OW-1:0]       win_idx;
   logic                win_any;
   logic                owner_free;

   generate
      if (NUM_SICS == 1) begin : g_single
         assign win = rpl_req;
      end else begin : g_multi
         for (genvar g = 0; g < NUM_SICS; g++) begin : g_lane
            sic_alu_lock_lane #(
               .NUM_SICS (NUM_SICS),
               .ID_WIDTH (ID_WIDTH),
               .IDX      (g)
            ) u_lane (
               .req (rpl_req),
               .ids (rpl_issue_id),
               .win (win[g])
            );
         end
      end
   endgenerate

   // Lanes yield a single winner for legal id spans; the encoder keeps the grant one-hot regardless.
   always_comb begin
      win_idx    = '0;
      win_onehot = '0;
      win_any    = |win;
      for (int i = NUM_SICS - 1; i >= 0; i--)
         if (win[i]) win_idx = OW'(i);
      for (int i = 0; i < NUM_SICS; i++)
         win_onehot[i] = win_any && (win_idx == OW'(i));
   end

   assign owner_free = rpl_release[lock_owner] || !rpl_req[lock_owner];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         alu_grant  <= '0;
         lock_busy  <= 1'b0;
         lock_owner <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  state      <= LOCKED;
                  alu_grant  <= win_onehot;
                  lock_busy  <= 1'b1;
                  lock_owner <= win_idx;
               end
            end
            LOCKED: begin
               // Freeing always passes through IDLE, so successive owners are a cycle apart.
               if (owner_free) begin
                  state      <= IDLE;
                  alu_grant  <= '0;
                  lock_busy  <= 1'b0;
                  lock_owner <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      alu_req_out = '0;
      if (lock_busy) alu_req_out = sic_alu_req[lock_owner];
   end

   assign alu_ans = alu_ans_in;
endmodule

// File: tb/tb_sic_alu_lock_arbiter.sv
// Directed + randomized bench for sic_alu_lock_arbiter against an ownership model.
module tb_sic_alu_lock_arbiter;
   import sic_alu_lock_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0]        req;
   logic [N-1:0][W-1:0] ids;
   logic [N-1:0]        rel;
   alu_req_t [N-1:0]    sreq;
   logic [N-1:0]        grant;
   alu_req_t            req_out;
   alu_ans_t            ans_in;
   alu_ans_t            ans;
   logic                busy;
   logic [1:0]          owner;

   int vectors     = 0;
   int miscompares = 0;
   int m_owner     = -1;

   sic_alu_lock_arbiter #(.NUM_SICS(N), .ID_WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rpl_req      (req),
      .rpl_issue_id (ids),
      .rpl_release  (rel),
      .sic_alu_req  (sreq),
      .alu_grant    (grant),
      .alu_req_out  (req_out),
      .alu_ans_in   (ans_in),
      .alu_ans      (ans),
      .lock_busy    (busy),
      .lock_owner   (owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Oldest requester: signed distance from a reference id, smallest wins, ties to lowest index.
   function automatic int model_arb();
      int best = -1, bestd = 0, r = 0, d;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            if (best < 0) r = int'(ids[i]);
            d = (int'(ids[i]) - r + (1 << W)) % (1 << W);
            if (d >= (1 << (W - 1))) d -= (1 << W);
            if (best < 0 || d < bestd) begin
               best  = i;
               bestd = d;
            end
         end
      end
      return best;
   endfunction

   task automatic randomize_data();
      for (int i = 0; i < N; i++) begin
         sreq[i].op = 4'($urandom);
         sreq[i].a  = $urandom;
         sreq[i].b  = $urandom;
      end
      ans_in.res   = $urandom;
      ans_in.zero  = 1'($urandom);
      ans_in.carry = 1'($urandom);
   endtask

   task automatic check_regs();
      logic [N-1:0] eg;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("alu_grant", grant, eg);
      chk("lock_busy", busy, m_owner >= 0);
      chk("lock_owner", owner, (m_owner >= 0) ? m_owner : 0);
   endtask

   // One clock: check combinational steering, advance model, check registered state.
   task automatic step();
      int nxt;
      alu_req_t er;
      randomize_data();
      #1;
      er = '0;
      if (m_owner >= 0) er = sreq[m_owner];
      chk("alu_req_out", req_out, er);
      chk("alu_ans", ans, ans_in);
      if (m_owner < 0)                              nxt = model_arb();
      else if (rel[m_owner] || !req[m_owner])       nxt = -1;
      else                                          nxt = m_owner;
      @(posedge clk);
      #1;
      m_owner = nxt;
      check_regs();
      rel = '0;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      req   = '0;
      rel   = '0;
      ids   = '0;
      randomize_data();
      #12;
      chk("rst_grant", grant, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, '0);
      chk("rst_req_out", req_out, '0);
      chk("rst_ans", ans, ans_in);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single requester, release at cycle 3
      req[0] = 1'b1; ids[0] = 8'd5;
      step();
      chk("t1_grant", grant, 4'b0001);
      step();
      step();
      rel[0] = 1'b1; req[0] = 1'b0;
      step();
      chk("t1_free", grant, 4'b0000);

      // oldest of two, then one idle cycle before the next owner
      req = 4'b0110; ids[1] = 8'd9; ids[2] = 8'd7;
      step();
      chk("t2_first", grant, 4'b0100);
      step();
      rel[2] = 1'b1; req[2] = 1'b0;
      step();
      chk("t2_gap", grant, 4'b0000);
      step();
      chk("t2_second", grant, 4'b0010);
      rel[1] = 1'b1; req[1] = 1'b0;
      step();

      // wraparound age compare
      req = 4'b1001; ids[0] = 8'h02; ids[3] = 8'hFE;
      step();
      chk("t3_wrap", grant, 4'b1000);
      req = '0; rel[3] = 1'b1;
      step();

      // non-owner release ignored, then owner abort frees
      req[0] = 1'b1; ids[0] = 8'h10;
      step();
      rel[2] = 1'b1;
      step();
      chk("t4_hold", grant, 4'b0001);
      req[0] = 1'b0;
      step();
      chk("t4_abort", grant, 4'b0000);

      // no preemption by younger, async reset mid-lock
      req[1] = 1'b1; ids[1] = 8'h20;
      step();
      req[0] = 1'b1; ids[0] = 8'h21;
      step();
      chk("t5_nopreempt", grant, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      m_owner = -1;
      chk("t5_async_grant", grant, '0);
      chk("t5_async_busy", busy, 1'b0);
      chk("t5_async_req_out", req_out, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("t5_regrant", grant, 4'b0010);
      req = '0;
      step();

      // tie on equal ids
      req = 4'b1010; ids[1] = 8'd4; ids[3] = 8'd4;
      step();
      chk("t6_tie", grant, 4'b0010);
      req = '0;
      step();

      // randomized traffic within a legal id window
      repeat (400) begin
         base = int'($urandom_range(0, 255));
         for (int i = 0; i < N; i++) begin
            req[i] = ($urandom_range(0, 3) != 0);
            rel[i] = ($urandom_range(0, 4) == 0);
            ids[i] = W'(base + int'($urandom_range(0, 100)));
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sic_alu_lock_arbiter.md
Name: sic_alu_lock_arbiter

Overview:
- Shared-ALU lock manager that sits directly downstream of the per-SIC ALU execution sub-units.
- Collects each SIC's ALU lock request (req, req_issue_id, release_lock) and grants the single shared ALU to the oldest requesting instruction by issue_id.
- Holds the grant until that owner releases the lock.
- Steers the owner's ALU request to the shared ALU and broadcasts the ALU answer back to all SICs; an answer is valid only for the SIC whose grant bit is set.

Parameters:
- NUM_SICS, 4, number of SIC requesters (≥1).
- ID_WIDTH, 8, issue_id width; ids wrap modulo 2^ID_WIDTH. In-flight id span must stay below 2^(ID_WIDTH-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rpl_req  in  NUM_SICS  per-SIC lock request level.
- rpl_issue_id  in  NUM_SICS x ID_WIDTH  per-SIC issue_id of the requesting instruction.
- rpl_release  in  NUM_SICS  per-SIC one-cycle release pulse.
- sic_alu_req  in  NUM_SICS x alu_req_t  per-SIC ALU operation (op, a, b).
- alu_grant  out  NUM_SICS  one-hot-or-zero grant; registered.
- alu_req_out  out  alu_req_t  request forwarded to the shared ALU.
- alu_ans_in  in  alu_ans_t  shared ALU result (combinational from alu_req_out).
- alu_ans  out  alu_ans_t  broadcast of alu_ans_in to all SICs.
- lock_busy  out  1  lock currently held.
- lock_owner  out  clog2(NUM_SICS) (min 1)  index of the current owner; 0 when idle.

Behaviour:
- States:
  - IDLE: no owner.
  - LOCKED: owner register valid.
- Reset (async, rst_n low):
  - state=IDLE, alu_grant=0, lock_busy=0, lock_owner=0.
  - alu_req_out=0. alu_ans keeps following alu_ans_in.
  - Reset asserted mid-lock drops the grant immediately; no release pulse is required afterwards.
- Arbitration (IDLE only):
  - Among SICs with rpl_req=1, select the oldest issue_id.
  - Age compare: id_a is older than id_b iff the top bit of (id_a - id_b) mod 2^ID_WIDTH is 1.
  - Equal ids: lower SIC index wins.
  - On a winner: owner<=winner, state<=LOCKED.
  - alu_grant[winner] rises the next cycle, giving 1-cycle request-to-grant latency.
- LOCKED:
  - alu_grant = onehot(owner), lock_busy=1, alu_req_out = sic_alu_req[owner].
  - Requests from other SICs are held off; they simply keep req asserted.
  - A request from a younger instruction never preempts the owner.
- Release, evaluated every LOCKED cycle:
  - Lock frees when rpl_release[owner]=1, or when rpl_req[owner]=0. The second condition covers an owner that drops req because of a mispredict abort.
  - On free: state<=IDLE, and alu_grant is 0 in the following cycle.
  - No same-cycle re-grant. The minimum gap between successive owners is one IDLE cycle, so back-to-back owners see grant at cycles t and t+2 or later.
- rpl_release from a non-owner, or any release while IDLE, is ignored. A SIC that aborted before being granted still pulses release.
- Owner whose req stays high with no release holds the lock indefinitely. No timeout.
- IDLE with no requests: alu_req_out=0, grant=0.
- Single requester (NUM_SICS=1): same timing; the age compare is bypassed.
- alu_ans is a pure pass-through with no added latency, so the SIC commits in the same cycle it sees the grant.

Test Plan:
- Single SIC0 raises req with id=5 at cycle 0 → alu_grant=0001 at cycle 1 and alu_req_out=sic_alu_req[0]. Release pulse at cycle 3 → grant=0000 at cycle 4, lock_busy=0.
- SIC1 id=9 and SIC2 id=7 request together → SIC2 granted. After SIC2 releases: one idle cycle, then SIC1 granted.
- Wraparound: SIC0 id=0x02 and SIC3 id=0xFE request together (ID_WIDTH=8) → SIC3 (0xFE) granted as older.
- SIC0 owns the lock; SIC2 pulses release without owning and SIC2 req=0 → lock unchanged. SIC0 then drops req with no release → lock freed the next cycle.
- SIC1 locked; younger SIC0 (id+1) requests; rst_n pulsed low mid-lock → grant=0 asynchronously. After reset, SIC0 and SIC1 requesting again → the older of the two is granted at the first cycle after rst_n rises.
- Tie: SIC1 and SIC3 both id=4 → SIC1 granted.
